// File: rtl/reorder_buffer.sv
// In-order retirement buffer: out-of-order tagged completions, one retire/cycle; completion-to-write 2 edges.
// Backpressure: rob_iss_full rejects allocation (dropped, no state change); completion ports are never stalled.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_rob_alloc,
  input  logic [4:0]      iss_rob_regdest,
  input  logic            iss_rob_writereg,
  output logic [TAGW-1:0] rob_iss_tag,
  output logic            rob_iss_full,
  input  logic            am_rob_oper,
  input  logic [TAGW-1:0] am_rob_tag,
  input  logic [31:0]     am_rob_wbvalue,
  input  logic            mem_rob_oper,
  input  logic [TAGW-1:0] mem_rob_tag,
  input  logic [31:0]     mem_rob_wbvalue,
  input  logic            mul_rob_oper,
  input  logic [TAGW-1:0] mul_rob_tag,
  input  logic [31:0]     mul_rob_wbvalue,
  output logic            rob_reg_en,
  output logic [4:0]      rob_reg_addr,
  output logic [31:0]     rob_reg_data,
  output logic            rob_empty,
  output logic [TAGW:0]   rob_count
);

  localparam logic [TAGW:0] FULL_CNT = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] wr_q;
  logic [4:0]       dest_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [TAGW-1:0]  head_q;
  logic [TAGW-1:0]  tail_q;
  logic [TAGW:0]    count_q;

  logic             alloc_acc;
  logic             retire;
  logic [DEPTH-1:0] cmp_hit;
  logic [31:0]      cmp_val [DEPTH];

  assign rob_iss_full = (count_q == FULL_CNT);
  assign rob_empty    = (count_q == '0);
  assign rob_count    = count_q;
  assign rob_iss_tag  = tail_q;
  assign alloc_acc    = iss_rob_alloc && !rob_iss_full;
  assign retire       = valid_q[head_q] && done_q[head_q];

  // Later assignments win, giving mem > am > mul on a tag collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cmp_hit[i] = 1'b0;
      cmp_val[i] = val_q[i];
      if (mul_rob_oper && mul_rob_tag == TAGW'(i)) begin
        cmp_hit[i] = 1'b1;
        cmp_val[i] = mul_rob_wbvalue;
      end
      if (am_rob_oper && am_rob_tag == TAGW'(i)) begin
        cmp_hit[i] = 1'b1;
        cmp_val[i] = am_rob_wbvalue;
      end
      if (mem_rob_oper && mem_rob_tag == TAGW'(i)) begin
        cmp_hit[i] = 1'b1;
        cmp_val[i] = mem_rob_wbvalue;
      end
      cmp_hit[i] = cmp_hit[i] && valid_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rob_reg_en   <= 1'b0;
      rob_reg_addr <= '0;
      rob_reg_data <= '0;
    end else begin
      done_q <= done_q | cmp_hit;
      if (alloc_acc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + TAGW'(1);
      end
      // Head and tail only coincide when empty or full, so alloc and retire never touch one entry.
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TAGW'(1);
        rob_reg_en      <= wr_q[head_q] && (dest_q[head_q] != 5'd0);
        rob_reg_addr    <= dest_q[head_q];
        rob_reg_data    <= val_q[head_q];
      end else begin
        rob_reg_en <= 1'b0;
      end
      count_q <= count_q + {{TAGW{1'b0}}, alloc_acc} - {{TAGW{1'b0}}, retire};
    end
  end

  // Payload storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cmp_hit[i]) val_q[i] <= cmp_val[i];
    end
    if (alloc_acc) begin
      dest_q[tail_q] <= iss_rob_regdest;
      wr_q[tail_q]   <= iss_rob_writereg;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order completion buffer between the issue stage and the register file write port. Issue allocates one entry per dispatched operation and receives a tag. The AluMisc, Mem and Mult units return results out of order, tagged. The buffer retires finished entries strictly in allocation order, one per cycle, driving the register file write port in place of the direct writeback arbiter.

## Interface
- DEPTH, 8, number of entries; must be a power of two ≥ 2
- TAGW, 3, tag width; equals log2(DEPTH)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- iss_rob_alloc  in  1  issue requests an entry this cycle
- iss_rob_regdest  in  5  destination register of the allocating op
- iss_rob_writereg  in  1  op writes a register
- rob_iss_tag  out  TAGW  tag granted to the allocating op (combinational; equals the tail pointer)
- rob_iss_full  out  1  no free entry; an allocation in this cycle is ignored
- am_rob_oper / mem_rob_oper / mul_rob_oper  in  1  unit result valid this cycle
- am_rob_tag / mem_rob_tag / mul_rob_tag  in  TAGW  tag of the completing op
- am_rob_wbvalue / mem_rob_wbvalue / mul_rob_wbvalue  in  32  result value
- rob_reg_en  out  1  register file write enable
- rob_reg_addr  out  5  register file write address
- rob_reg_data  out  32  register file write data
- rob_empty  out  1  no valid entries
- rob_count  out  TAGW+1  number of valid entries

## Operation
- Per-entry state: valid, done, writereg, regdest[4:0], value[31:0]. Pointers: head and tail (TAGW bits, natural wrap DEPTH-1 → 0). Counter: count (TAGW+1 bits).
- Allocate: when iss_rob_alloc=1 and count<DEPTH:
  - The entry at tail is written with valid=1, done=0, regdest and writereg.
  - tail increments.
  - When count==DEPTH, the request is dropped and no state changes.
- Complete: for each unit with oper=1 whose tag addresses a valid entry, that entry gets value and done=1.
  - Completions to an invalid entry are ignored.
  - Distinct tags in the same cycle are all accepted.
  - If two units name the same tag in one cycle (a protocol error), priority is mem > am > mul.
- Retire: at most one entry per edge. If the head entry has valid=1 and done=1:
  - Clear valid and increment head.
  - Register rob_reg_en = writereg && (regdest != 0), rob_reg_addr = regdest, rob_reg_data = value.
  - Otherwise rob_reg_en=0, and addr/data hold their previous values.
- Retirement is strictly in order. A done entry behind a not-done head waits.
- count_next = count + alloc_accepted − retired. Allocate and retire in the same cycle leave count unchanged.
- rob_iss_full = (count==DEPTH) and rob_empty = (count==0). Both are combinational from registered count, so full is judged on the pre-edge count even if a retire happens in the same cycle.
- Reset (reset=0, asynchronous):
  - All valid/done cleared; head=tail=count=0.
  - rob_reg_en=0, rob_reg_addr=0, rob_reg_data=0.
  - rob_iss_tag=0, rob_iss_full=0, rob_empty=1, rob_count=0.
  - Reset mid-operation discards all in-flight entries; no write occurs after reset asserts.

## Timing
- Allocation takes effect at edge A. rob_iss_tag is valid combinationally during the request cycle before A.
- A completion sampled at edge C sets done. The earliest retire decision for that entry is edge C+1, and rob_reg_en is high in the cycle following C+1. Minimum completion-to-write latency: 2 edges.
- A completion and a retire decision never interact in the same edge, because retire reads registered done.
- Sustained throughput: one allocation and one retirement per cycle.
- rob_reg_en is a single-cycle pulse per retired writing entry. Back-to-back retires produce consecutive high cycles.
- Reset release: the first allocation is accepted at the first rising edge with reset=1.

## Test plan
- Out-of-order completion:
  - Stimulus: allocate r1, r2, r3 (tags 0, 1, 2, writereg=1). Complete tag 2 via mul with 0x33, then tag 0 via am with 0x11, then tag 1 via mem with 0x22, one per cycle.
  - Response: writes r1=0x11, then r2=0x22, then r3=0x33 on consecutive cycles. Nothing is written before tag 1 completes except r1.
- Full boundary:
  - Stimulus: allocate 8 entries with no completions, then attempt a 9th.
  - Response: full=1 and count=8. The 9th is ignored and tail stays 0. Complete tag 0; one cycle after retire, full=0 and count=7.
- Simultaneous completions:
  - Stimulus: 3 entries allocated. am, mem and mul complete tags 0, 1, 2 with 0xA, 0xB, 0xC in one cycle.
  - Response: three consecutive rob_reg_en pulses with data 0xA, 0xB, 0xC.
- Non-writing and r0 entries:
  - Stimulus: entries with writereg=0, and with regdest=0 and writereg=1, both completed.
  - Response: both retire (count decrements) with rob_reg_en=0.
- Wrap-around:
  - Stimulus: 20 alloc/complete/retire cycles.
  - Response: tags sequence 0..7, 0..7, 0..3. Writes occur in allocation order and count never exceeds 8.
- Reset mid-operation:
  - Stimulus: 5 entries allocated, 2 completed. Assert reset for one cycle.
  - Response: rob_reg_en=0 immediately; empty=1, count=0. The next allocation receives tag 0, and the earlier completions never write.
